// File: rtl/scale_pkg.sv
// Shared types and defaults for the scaling sequence controller.
// Mode encodings, FSM state enum, default parameter values and mode decode helpers.
package scale_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM_WAIT,
    ST_DS_RUN,
    ST_US_RUN,
    ST_HOLD,
    ST_ERR
  } state_t;

  localparam logic [1:0] MODE_DS   = 2'b01;
  localparam logic [1:0] MODE_US   = 2'b10;
  localparam logic [1:0] MODE_DSUS = 2'b11;

  localparam int HOLD_CYCLES_DEF = 33333300;
  localparam int HOLD_W_DEF      = 26;
  localparam int WDOG_CYCLES_DEF = 1048576;
  localparam int WDOG_W_DEF      = 21;
  localparam int FCNT_W_DEF      = 8;

  function automatic logic has_ds(input logic [1:0] mode);
    return mode[0];
  endfunction

  function automatic logic has_us(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/scale_seq_ctrl_seq_timer.sv
// seq_timer: loadable down-counter that stops at zero and flags it (tc).
// Shared by the HOLD interval and the per-stage watchdog.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/scale_seq_ctrl.sv
// Scaling sequence controller: ROM wait, downsample, upsample, hold, with abort.
// Optional per-stage watchdog and ERR state enabled by defining SCALE_SEQ_WDOG_EN.
module scale_seq_ctrl
  import scale_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int HOLD_W      = HOLD_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
  parameter int WDOG_W      = WDOG_W_DEF,
  parameter int FCNT_W      = FCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              abort_i,
  input  logic              rom_rd_valid_i,
  input  logic              ds_done_i,
  input  logic              us_done_i,
  output logic              run_o,
  output logic              ds_run_o,
  output logic              us_run_o,
  output logic              rom_rd_done_o,
  output logic              done_o,
  output logic              done_led_o,
  output logic              mode_err_o,
  output logic              err_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);

  state_t     state, state_nxt;
  logic [1:0] mode_q;
  logic       mode_ld, mode_err_nxt, rom_done_nxt, done_nxt;
  logic       hold_tc, wdog_exp;

  seq_timer #(.W(HOLD_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     ((state_nxt == ST_HOLD) && (state != ST_HOLD)),
    .en       (state == ST_HOLD),
    .load_val (HOLD_W'(HOLD_CYCLES - 1)),
    .tc       (hold_tc)
  );

`ifdef SCALE_SEQ_WDOG_EN
  logic wdog_tc, wdog_en;

  // Re-arms on every state change so each stage gets a fresh budget.
  assign wdog_en = (state == ST_ROM_WAIT) || (state == ST_DS_RUN) || (state == ST_US_RUN);

  seq_timer #(.W(WDOG_W)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .load     (state_nxt != state),
    .en       (wdog_en),
    .load_val (WDOG_W'(WDOG_CYCLES - 1)),
    .tc       (wdog_tc)
  );

  assign wdog_exp = wdog_en && wdog_tc;
  assign err_o    = (state == ST_ERR);
`else
  assign wdog_exp = 1'b0;
  assign err_o    = 1'b0;
`endif

  // Abort beats any completion; a completion beats a simultaneous timeout.
  always_comb begin
    state_nxt    = state;
    mode_ld      = 1'b0;
    mode_err_nxt = 1'b0;
    rom_done_nxt = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (mode_i == 2'b00) begin
            mode_err_nxt = 1'b1;
          end else begin
            state_nxt = ST_ROM_WAIT;
            mode_ld   = 1'b1;
          end
        end
      end
      ST_ROM_WAIT: begin
        if (abort_i)             state_nxt = ST_IDLE;
        else if (rom_rd_valid_i) state_nxt = has_ds(mode_q) ? ST_DS_RUN : ST_US_RUN;
        else if (wdog_exp)       state_nxt = ST_ERR;
      end
      ST_DS_RUN: begin
        if (abort_i) begin
          state_nxt = ST_IDLE;
        end else if (ds_done_i) begin
          rom_done_nxt = 1'b1;
          state_nxt    = has_us(mode_q) ? ST_US_RUN : ST_HOLD;
        end else if (wdog_exp) begin
          state_nxt = ST_ERR;
        end
      end
      ST_US_RUN: begin
        if (abort_i) begin
          state_nxt = ST_IDLE;
        end else if (us_done_i) begin
          rom_done_nxt = !has_ds(mode_q);
          state_nxt    = ST_HOLD;
        end else if (wdog_exp) begin
          state_nxt = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (abort_i) begin
          state_nxt = ST_IDLE;
        end else if (hold_tc) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (abort_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      mode_err_o    <= 1'b0;
      rom_rd_done_o <= 1'b0;
      done_o        <= 1'b0;
      done_led_o    <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      state         <= state_nxt;
      mode_err_o    <= mode_err_nxt;
      rom_rd_done_o <= rom_done_nxt;
      done_o        <= done_nxt;
      if (mode_ld)       done_led_o <= 1'b0;
      else if (done_nxt) done_led_o <= 1'b1;
      if (done_nxt)      frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mode_ld) mode_q <= mode_i;
  end

  assign run_o    = (state != ST_IDLE) && (state != ST_ERR);
  assign ds_run_o = (state == ST_DS_RUN);
  assign us_run_o = (state == ST_US_RUN);

endmodule

// File: tb/tb_scale_seq_ctrl.sv
// Bench for scale_seq_ctrl: directed scenarios plus random traffic against a
// stage-queue reference model; watchdog checks follow SCALE_SEQ_WDOG_EN.
module tb_scale_seq_ctrl;

  localparam int HOLD_CYCLES = 4;
  localparam int HOLD_W      = 3;
  localparam int WDOG_CYCLES = 16;
  localparam int WDOG_W      = 5;
  localparam int FCNT_W      = 2;
`ifdef SCALE_SEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam int S_ROM  = 0;
  localparam int S_DS   = 1;
  localparam int S_US   = 2;
  localparam int S_HOLD = 3;

  logic              clk = 1'b0;
  logic              rst, start_i, abort_i, rom_rd_valid_i, ds_done_i, us_done_i;
  logic [1:0]        mode_i;
  logic              run_o, ds_run_o, us_run_o, rom_rd_done_o, done_o, done_led_o;
  logic              mode_err_o, err_o;
  logic [FCNT_W-1:0] frame_cnt_o;

  scale_seq_ctrl #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_W      (HOLD_W),
    .WDOG_CYCLES (WDOG_CYCLES),
    .WDOG_W      (WDOG_W),
    .FCNT_W      (FCNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .abort_i        (abort_i),
    .rom_rd_valid_i (rom_rd_valid_i),
    .ds_done_i      (ds_done_i),
    .us_done_i      (us_done_i),
    .run_o          (run_o),
    .ds_run_o       (ds_run_o),
    .us_run_o       (us_run_o),
    .rom_rd_done_o  (rom_rd_done_o),
    .done_o         (done_o),
    .done_led_o     (done_led_o),
    .mode_err_o     (mode_err_o),
    .err_o          (err_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the sequence is a queue of remaining stages.
  int         stages[$];
  int         age;
  logic [1:0] m_mode;
  bit         m_led, m_err, m_merr, m_rdone, m_done;
  int         m_fcnt;

  function automatic void model_step();
    int  cur;
    bit  advance;
    m_merr  = 1'b0;
    m_rdone = 1'b0;
    m_done  = 1'b0;
    if (rst) begin
      stages.delete();
      m_led  = 1'b0;
      m_err  = 1'b0;
      m_fcnt = 0;
      age    = 0;
    end else if (m_err) begin
      if (abort_i) m_err = 1'b0;
    end else if (stages.size() == 0) begin
      if (start_i) begin
        if (mode_i == 2'b00) begin
          m_merr = 1'b1;
        end else begin
          m_mode = mode_i;
          stages.push_back(S_ROM);
          if (mode_i[0]) stages.push_back(S_DS);
          if (mode_i[1]) stages.push_back(S_US);
          stages.push_back(S_HOLD);
          m_led = 1'b0;
          age   = 0;
        end
      end
    end else begin
      cur = stages[0];
      advance = (cur == S_ROM  && rom_rd_valid_i) ||
                (cur == S_DS   && ds_done_i) ||
                (cur == S_US   && us_done_i) ||
                (cur == S_HOLD && age == HOLD_CYCLES - 1);
      if (abort_i) begin
        stages.delete();
      end else if (advance) begin
        void'(stages.pop_front());
        if (cur == S_DS) m_rdone = 1'b1;
        if (cur == S_US && m_mode == 2'b10) m_rdone = 1'b1;
        if (cur == S_HOLD) begin
          m_done = 1'b1;
          m_led  = 1'b1;
          m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
        end
        age = 0;
      end else if (WDOG_ON && cur != S_HOLD && age == WDOG_CYCLES - 1) begin
        m_err = 1'b1;
        stages.delete();
      end else begin
        age++;
      end
    end
  endfunction

  int n_rdone, n_done, n_merr, n_ds, n_run;

  task automatic compare();
    check("run_o",       int'(run_o),       int'(stages.size() > 0));
    check("ds_run_o",    int'(ds_run_o),    int'(stages.size() > 0 && stages[0] == S_DS));
    check("us_run_o",    int'(us_run_o),    int'(stages.size() > 0 && stages[0] == S_US));
    check("rom_rd_done", int'(rom_rd_done_o), int'(m_rdone));
    check("done_o",      int'(done_o),      int'(m_done));
    check("done_led_o",  int'(done_led_o),  int'(m_led));
    check("mode_err_o",  int'(mode_err_o),  int'(m_merr));
    check("err_o",       int'(err_o),       int'(m_err));
    check("frame_cnt_o", int'(frame_cnt_o), m_fcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    n_rdone += int'(rom_rd_done_o);
    n_done  += int'(done_o);
    n_merr  += int'(mode_err_o);
    n_ds    += int'(ds_run_o);
    n_run   += int'(run_o);
  endtask

  task automatic drive(input bit st, input logic [1:0] md, input bit ab,
                       input bit va, input bit dd, input bit ud);
    start_i        = st;
    mode_i         = md;
    abort_i        = ab;
    rom_rd_valid_i = va;
    ds_done_i      = dd;
    us_done_i      = ud;
  endtask

  task automatic clear_counts();
    n_rdone = 0; n_done = 0; n_merr = 0; n_ds = 0; n_run = 0;
  endtask

  task automatic do_reset();
    drive(0, 2'b00, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'b00, 0, 0, 0, 0);
    stages.delete();
    age = 0; m_mode = 2'b00; m_led = 0; m_err = 0; m_fcnt = 0;
    m_merr = 0; m_rdone = 0; m_done = 0;
    clear_counts();
    do_reset();

    // DS then US: valid +2, ds_done +5, us_done +9
    clear_counts();
    for (int c = 0; c < 20; c++) begin
      drive(c == 0, (c == 0) ? 2'b11 : 2'(c), 0, c == 2, c == 5, c == 9);
      tick();
    end
    check("dsus_rdone_pulses", n_rdone, 1);
    check("dsus_done_pulses", n_done, 1);
    check("dsus_frame_cnt", int'(frame_cnt_o), 1);

    // Four US-only sequences wrap the 2-bit frame counter
    do_reset();
    clear_counts();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 12; c++) begin
        drive(c == 0, 2'b10, 0, c == 2, c == 3, c == 4);
        tick();
      end
    end
    check("us_ds_run_seen", n_ds, 0);
    check("us_rdone_pulses", n_rdone, 4);
    check("us_frame_wrap", int'(frame_cnt_o), 0);

    // Illegal mode, then a start ignored while in DS_RUN
    clear_counts();
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 2'b00, 0, 0, 0, 0);
      tick();
    end
    check("illegal_merr_pulses", n_merr, 1);
    check("illegal_run_cycles", n_run, 0);
    for (int c = 0; c < 16; c++) begin
      drive(c == 0 || c == 4, (c == 4) ? 2'b10 : 2'b01, 0, c == 2, c == 6, c == 5);
      tick();
    end

    // Stall in DS_RUN
    for (int c = 0; c < 22; c++) begin
      drive(c == 0, 2'b01, 0, c == 1, 0, 0);
      tick();
    end
    check("stall_err", int'(err_o), int'(WDOG_ON));
    check("stall_run", int'(run_o), int'(!WDOG_ON));
    drive(0, 2'b00, 1, 0, 0, 0);
    tick();
    check("abort_err_clear", int'(err_o), 0);
    check("abort_run_clear", int'(run_o), 0);

    // Abort coincident with us_done
    clear_counts();
    for (int c = 0; c < 10; c++) begin
      drive(c == 0, 2'b10, c == 4, c == 1, 0, c == 4);
      tick();
    end
    check("abort_no_done", n_done, 0);
    check("abort_no_rdone", n_rdone, 0);

    // Reset while in HOLD
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 2'b01, 0, c == 1, c == 3, 0);
      rst = (c == 5);
      tick();
    end
    rst = 1'b0;
    check("rst_hold_run", int'(run_o), 0);
    check("rst_hold_fcnt", int'(frame_cnt_o), 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 9) < 3, 2'($urandom), $urandom_range(0, 99) < 3,
            $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 15);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
